// File: rtl/shift_out_driver_pkg.sv
// Shared types and helpers for the 74HC595-style serial output driver.
package shift_out_driver_pkg;

    // Transfer phases: wait for a word, shift-clock low, shift-clock high, latch pulse.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    // Number of bits needed to hold 'value' (never less than 1).
    function automatic int unsigned GET_WIDTH(input int unsigned value);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((value >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/shift_out_driver.sv
// Serialises a parallel word onto a 74HC595-style chain: shift clock, data, latch, clear.
module shift_out_driver
    import shift_out_driver_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 16,
    parameter int unsigned HALF_PERIOD = 2,
    parameter bit          MSB_FIRST   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 busy,
    output logic                 done,
    output logic                 s_clk,
    output logic                 s_dat,
    output logic                 s_lat,
    output logic                 s_clr_n
);

    localparam int unsigned DIV_W = GET_WIDTH(HALF_PERIOD - 1);
    localparam int unsigned CNT_W = GET_WIDTH(DATA_BITS);

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] sr_q, sr_d;
    logic [DATA_BITS-1:0] sr_shift;
    logic                 phase_end;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 s_clk_q, s_clk_d;
    logic                 s_dat_q, s_dat_d;
    logic                 s_lat_q, s_lat_d;
    logic                 s_clr_n_q;

    // Next-state logic; pin outputs are derived from the next state so they leave a flop.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        s_dat_d   = s_dat_q;
        done_d    = 1'b0;
        phase_end = (div_q == DIV_W'(HALF_PERIOD - 1));
        sr_shift  = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_d    = data;
                    cnt_d   = CNT_W'(DATA_BITS);
                    div_d   = '0;
                    s_dat_d = MSB_FIRST ? data[DATA_BITS-1] : data[0];
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    div_d   = '0;
                    state_d = ST_HIGH;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    div_d = '0;
                    cnt_d = cnt_q - CNT_W'(1);
                    sr_d  = sr_shift;
                    if (cnt_q == CNT_W'(1)) begin
                        // last bit stays on s_dat through the latch phase
                        state_d = ST_LATCH;
                    end else begin
                        s_dat_d = MSB_FIRST ? sr_shift[DATA_BITS-1] : sr_shift[0];
                        state_d = ST_LOW;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (phase_end) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        s_clk_d = (state_d == ST_HIGH);
        s_lat_d = (state_d == ST_LATCH);
    end

    // State and output registers; reset also holds the external chain cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            sr_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_clk_q   <= 1'b0;
            s_dat_q   <= 1'b0;
            s_lat_q   <= 1'b0;
            s_clr_n_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_clk_q   <= s_clk_d;
            s_dat_q   <= s_dat_d;
            s_lat_q   <= s_lat_d;
            s_clr_n_q <= 1'b1;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign s_clk   = s_clk_q;
    assign s_dat   = s_dat_q;
    assign s_lat   = s_lat_q;
    assign s_clr_n = s_clr_n_q;

endmodule

// File: tb/tb_shift_out_driver.sv
// Scoreboard bench: two driver instances (16 bits/HP=2/MSB-first and 8 bits/HP=1/LSB-first).
module tb_shift_out_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b;
    logic [15:0] data_a;
    logic [7:0]  data_b;
    logic        busy_a, done_a, sclk_a, sdat_a, slat_a, clrn_a;
    logic        busy_b, done_b, sclk_b, sdat_b, slat_b, clrn_b;

    shift_out_driver #(.DATA_BITS(16), .HALF_PERIOD(2), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data(data_a),
        .busy(busy_a), .done(done_a), .s_clk(sclk_a), .s_dat(sdat_a),
        .s_lat(slat_a), .s_clr_n(clrn_a)
    );

    shift_out_driver #(.DATA_BITS(8), .HALF_PERIOD(1), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data(data_b),
        .busy(busy_b), .done(done_b), .s_clk(sclk_b), .s_dat(sdat_b),
        .s_lat(slat_b), .s_clr_n(clrn_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        int unsigned e;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned edge_n = 0;
    int unsigned free0  = 0;
    int unsigned free1  = 0;
    int          checks = 0;
    int          errors = 0;

    // transfer length in cycles of busy: 2*HP*N + HP
    localparam int unsigned LEN0 = 2 * 2 * 16 + 2;
    localparam int unsigned LEN1 = 2 * 1 * 8 + 1;

    task automatic check(input string name, input int d, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h", name, d, act, exp);
        end
    endtask

    // Reference model: a start is taken when the driver is free; it is then busy for LEN
    // cycles, and the following done cycle is idle, so the next start can land one edge later.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            free0 = edge_n + 1;
            free1 = edge_n + 1;
        end else begin
            if (start_a && edge_n >= free0) begin
                q0.push_back('{w: data_a, e: edge_n});
                free0 = edge_n + LEN0 + 1;
            end
            if (start_b && edge_n >= free1) begin
                q1.push_back('{w: {8'h00, data_b}, e: edge_n});
                free1 = edge_n + LEN1 + 1;
            end
        end
        edge_n++;
    end

    // Monitor: observes the pins, rebuilds each transfer and checks it when done pulses.
    logic        pb[2]    = '{1'b0, 1'b0};
    logic        pclk[2]  = '{1'b0, 1'b0};
    logic        pdat[2]  = '{1'b0, 1'b0};
    int unsigned run[2]   = '{0, 0};
    int unsigned edges[2] = '{0, 0};
    int unsigned lat[2]   = '{0, 0};
    int unsigned sedge[2] = '{0, 0};
    logic [15:0] rx[2]    = '{16'h0, 16'h0};
    bit          bad[2]   = '{1'b0, 1'b0};

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            logic        bsy, dn, sc, sd, sl, cn;
            int unsigned n, hp, len;
            bit          msb, have;
            exp_t        ex;
            logic [15:0] expw;
            bsy = (d == 0) ? busy_a : busy_b;
            dn  = (d == 0) ? done_a : done_b;
            sc  = (d == 0) ? sclk_a : sclk_b;
            sd  = (d == 0) ? sdat_a : sdat_b;
            sl  = (d == 0) ? slat_a : slat_b;
            cn  = (d == 0) ? clrn_a : clrn_b;
            n   = (d == 0) ? 16 : 8;
            hp  = (d == 0) ? 2 : 1;
            len = (d == 0) ? LEN0 : LEN1;
            msb = (d == 0);
            if (!cn) begin
                run[d] = 0; edges[d] = 0; lat[d] = 0; rx[d] = '0; bad[d] = 1'b0;
            end else begin
                if (bsy) begin
                    if (!pb[d]) sedge[d] = edge_n - 1;
                    run[d]++;
                    if (sl) lat[d]++;
                    if (sc && !pclk[d]) begin
                        edges[d]++;
                        rx[d] = {rx[d][14:0], sd};
                        if (sd != pdat[d]) bad[d] = 1'b1;
                    end
                    if (sl && (sc || edges[d] != n)) bad[d] = 1'b1;
                end else begin
                    check("idle_pins_low", d, {sc, sl}, 0);
                end
                if (dn) begin
                    have = 1'b0;
                    if (d == 0 && q0.size() > 0) begin ex = q0.pop_front(); have = 1'b1; end
                    if (d == 1 && q1.size() > 0) begin ex = q1.pop_front(); have = 1'b1; end
                    check("done_expected", d, have, 1);
                    if (have) begin
                        expw = '0;
                        for (int i = 0; i < n; i++)
                            expw = {expw[14:0], msb ? ex.w[n-1-i] : ex.w[i]};
                        check("bit_stream", d, rx[d], expw);
                        check("rise_count", d, edges[d], n);
                        check("busy_len", d, run[d], len);
                        check("latch_len", d, lat[d], hp);
                        check("accept_edge", d, sedge[d], ex.e);
                        check("done_after_busy", d, {pb[d], bsy}, 2'b10);
                        check("timing_flags", d, bad[d], 0);
                    end
                    run[d] = 0; edges[d] = 0; lat[d] = 0; rx[d] = '0; bad[d] = 1'b0;
                end else if (pb[d] && !bsy) begin
                    check("busy_fell_without_done", d, 1, 0);
                end
            end
            pb[d] = bsy; pclk[d] = sc; pdat[d] = sd;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_pins();
        check("rst_pins_a", 0, {busy_a, done_a, sclk_a, sdat_a, slat_a, clrn_a}, 0);
        check("rst_pins_b", 1, {busy_b, done_b, sclk_b, sdat_b, slat_b, clrn_b}, 0);
    endtask

    task automatic wait_idle(input int unsigned maxc);
        int unsigned k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy_a || busy_b) && k < maxc) begin
            cyc();
            k++;
        end
        check("drain_timeout", 0, q0.size() + q1.size() + int'(busy_a) + int'(busy_b), 0);
    endtask

    task automatic pulse(input logic [15:0] wa, input logic [7:0] wb);
        start_a = 1'b1; data_a = wa; start_b = 1'b1; data_b = wb;
        cyc();
        start_a = 1'b0; start_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
        repeat (3) cyc();
        check_reset_pins();
        rst = 1'b0;
        cyc();
        check("clr_n_release", 0, {clrn_a, clrn_b}, 2'b11);

        // directed words, then a start/data change during the transfer that must be ignored
        pulse(16'hA5C3, 8'h3C);
        repeat (10) cyc();
        pulse(16'hFFFF, 8'hFF);
        data_a = 16'h1234; data_b = 8'h5A;
        wait_idle(200);
        pulse(16'h0001, 8'h01);
        wait_idle(200);

        // random sparse starts, many landing while busy
        repeat (400) begin
            start_a = ($urandom % 8) == 0; data_a = 16'($urandom);
            start_b = ($urandom % 8) == 0; data_b = 8'($urandom);
            cyc();
        end
        start_a = 1'b0; start_b = 1'b0;
        wait_idle(200);

        // start held high: back-to-back transfers with a single idle (done) cycle
        start_a = 1'b1; start_b = 1'b1;
        repeat (200) begin
            data_a = 16'($urandom); data_b = 8'($urandom);
            cyc();
        end
        start_a = 1'b0; start_b = 1'b0;
        wait_idle(200);

        // reset in cycle 20 of a transfer aborts it without a done pulse
        pulse(16'($urandom), 8'($urandom));
        repeat (19) cyc();
        rst = 1'b1;
        cyc();
        check_reset_pins();
        rst = 1'b0;
        cyc();
        check("clr_n_after_abort", 0, {clrn_a, clrn_b, done_a, done_b}, 4'b1100);
        pulse(16'($urandom), 8'($urandom));
        wait_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
